// File: rtl/parking_display_seq.sv
// Registered six-digit HEX driver for the parking lot: free-slot count by day, blinking
// FULL when the lot is full, and an end-of-day scroll through the car-track RAM.
module parking_display_seq #(
    parameter int N_SLOTS      = 3,
    parameter int N_HOURS      = 8,
    parameter int ADDR_W       = 3,
    parameter int DATA_W       = 16,
    parameter int SCROLL_TICKS = 4,
    parameter int BLINK_TICKS  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_SLOTS-1:0]  parking_status,
    input  logic [3:0]          work_hour,
    input  logic                work_day_expired,
    input  logic [3:0]          rush_start,
    input  logic                rush_start_exist,
    input  logic [3:0]          rush_end,
    input  logic                rush_end_exist,
    output logic [ADDR_W-1:0]   ram_addr,
    input  logic [DATA_W-1:0]   ram_data,
    output logic [6:0]          HEX0,
    output logic [6:0]          HEX1,
    output logic [6:0]          HEX2,
    output logic [6:0]          HEX3,
    output logic [6:0]          HEX4,
    output logic [6:0]          HEX5
);

    localparam int DWELL_W = $clog2(SCROLL_TICKS);
    localparam int BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(N_HOURS - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCROLL_TICKS - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);

    localparam logic [6:0] GLYPH_F     = 7'b0001110;
    localparam logic [6:0] GLYPH_U     = 7'b1000001;
    localparam logic [6:0] GLYPH_L     = 7'b1000111;
    localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        DAY    = 2'd0,
        FULL   = 2'd1,
        REVIEW = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [BLINK_W-1:0]  blink_cnt_reg, blink_cnt_next;
    logic                blink_on_reg, blink_on_next;
    logic [DWELL_W-1:0]  dwell_reg, dwell_next;
    logic [ADDR_W-1:0]   ram_addr_reg, ram_addr_next;
    logic [6:0]          hex_reg  [0:5];
    logic [6:0]          hex_next [0:5];

    logic [4:0]          occupied;
    logic [4:0]          free;
    logic [6:0]          count_sat;

    // Decimal digit glyph; anything above 9 renders as a dash.
    function automatic logic [6:0] seg_digit(input logic [7:0] value);
        logic [6:0] g;
        case (value)
            8'd0:    g = 7'b1000000;
            8'd1:    g = 7'b1111001;
            8'd2:    g = 7'b0100100;
            8'd3:    g = 7'b0110000;
            8'd4:    g = 7'b0011001;
            8'd5:    g = 7'b0010010;
            8'd6:    g = 7'b0000010;
            8'd7:    g = 7'b1111000;
            8'd8:    g = 7'b0000000;
            8'd9:    g = 7'b0010000;
            default: g = GLYPH_DASH;
        endcase
        return g;
    endfunction

    always_comb begin
        occupied = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            occupied = occupied + 5'(parking_status[i]);
        end
    end

    assign free = 5'(N_SLOTS) - occupied;

    always_comb begin
        if (ram_data > DATA_W'(99)) begin
            count_sat = 7'd99;
        end else begin
            count_sat = ram_data[6:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= DAY;
            blink_cnt_reg <= '0;
            blink_on_reg  <= 1'b1;
            dwell_reg     <= '0;
            ram_addr_reg  <= '0;
            for (int i = 0; i < 6; i++) begin
                hex_reg[i] <= GLYPH_BLANK;
            end
        end else begin
            state_reg     <= state_next;
            blink_cnt_reg <= blink_cnt_next;
            blink_on_reg  <= blink_on_next;
            dwell_reg     <= dwell_next;
            ram_addr_reg  <= ram_addr_next;
            for (int i = 0; i < 6; i++) begin
                hex_reg[i] <= hex_next[i];
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        blink_cnt_next = blink_cnt_reg;
        blink_on_next  = blink_on_reg;
        dwell_next     = dwell_reg;
        ram_addr_next  = ram_addr_reg;
        for (int i = 0; i < 6; i++) begin
            hex_next[i] = hex_reg[i];
        end

        // Expiry outranks the full/not-full decision in DAY and FULL.
        case (state_reg)
            DAY: begin
                if (work_day_expired) begin
                    state_next    = REVIEW;
                    ram_addr_next = LAST_ADDR;
                    dwell_next    = '0;
                end else if (free == 5'd0) begin
                    state_next     = FULL;
                    blink_cnt_next = '0;
                    blink_on_next  = 1'b1;
                end
            end
            FULL: begin
                if (work_day_expired) begin
                    state_next    = REVIEW;
                    ram_addr_next = LAST_ADDR;
                    dwell_next    = '0;
                end else if (free != 5'd0) begin
                    state_next = DAY;
                end else if (blink_cnt_reg == BLINK_LAST) begin
                    blink_cnt_next = '0;
                    blink_on_next  = ~blink_on_reg;
                end else begin
                    blink_cnt_next = blink_cnt_reg + 1'b1;
                end
            end
            REVIEW: begin
                if (!work_day_expired) begin
                    state_next = DAY;
                end else if (dwell_reg == DWELL_LAST) begin
                    dwell_next    = '0;
                    ram_addr_next = (ram_addr_reg == '0) ? LAST_ADDR : ram_addr_reg - 1'b1;
                end else begin
                    dwell_next = dwell_reg + 1'b1;
                end
            end
            default: begin
                state_next = DAY;
            end
        endcase

        hex_next[5] = seg_digit(8'(work_hour));

        // The display follows the state being entered so DAY/FULL react in one clock.
        case (state_next)
            DAY: begin
                hex_next[0] = seg_digit(8'(free % 5'd10));
                hex_next[1] = (free >= 5'd10) ? seg_digit(8'd1) : GLYPH_BLANK;
                hex_next[2] = GLYPH_BLANK;
                hex_next[3] = GLYPH_BLANK;
                hex_next[4] = GLYPH_BLANK;
            end
            FULL: begin
                hex_next[3] = blink_on_next ? GLYPH_F : GLYPH_BLANK;
                hex_next[2] = blink_on_next ? GLYPH_U : GLYPH_BLANK;
                hex_next[1] = blink_on_next ? GLYPH_L : GLYPH_BLANK;
                hex_next[0] = blink_on_next ? GLYPH_L : GLYPH_BLANK;
                hex_next[4] = GLYPH_BLANK;
            end
            REVIEW: begin
                if (rush_start_exist && rush_end_exist) begin
                    hex_next[4] = seg_digit(8'(rush_end));
                    hex_next[3] = seg_digit(8'(rush_start));
                end else if (rush_start_exist) begin
                    hex_next[4] = GLYPH_DASH;
                    hex_next[3] = seg_digit(8'(rush_start));
                end else begin
                    hex_next[4] = GLYPH_DASH;
                    hex_next[3] = GLYPH_DASH;
                end
                // Address digit lags the address by a cycle; data lags it by one more.
                hex_next[2] = seg_digit(8'(ram_addr_reg));
                if (state_reg == REVIEW && dwell_reg == DWELL_W'(1)) begin
                    hex_next[1] = seg_digit(8'(count_sat / 7'd10));
                    hex_next[0] = seg_digit(8'(count_sat % 7'd10));
                end
            end
            default: begin
                for (int i = 0; i < 5; i++) begin
                    hex_next[i] = GLYPH_BLANK;
                end
            end
        endcase
    end

    assign ram_addr = ram_addr_reg;
    assign HEX0     = hex_reg[0];
    assign HEX1     = hex_reg[1];
    assign HEX2     = hex_reg[2];
    assign HEX3     = hex_reg[3];
    assign HEX4     = hex_reg[4];
    assign HEX5     = hex_reg[5];

endmodule

// File: tb/tb_parking_display_seq.sv
// Directed bench for parking_display_seq: day count, FULL blink, review scroll with a
// one-cycle-latency RAM model, rush-hour digits and mid-operation reset.
module tb_parking_display_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  parking_status;
    logic [3:0]  work_hour;
    logic        work_day_expired;
    logic [3:0]  rush_start;
    logic        rush_start_exist;
    logic [3:0]  rush_end;
    logic        rush_end_exist;
    logic [2:0]  ram_addr;
    logic [15:0] ram_data;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    int checks = 0;
    int passes = 0;

    localparam logic [6:0] G_F     = 7'b0001110;
    localparam logic [6:0] G_U     = 7'b1000001;
    localparam logic [6:0] G_L     = 7'b1000111;
    localparam logic [6:0] G_DASH  = 7'b0111111;
    localparam logic [6:0] G_BLANK = 7'b1111111;

    parking_display_seq #(
        .N_SLOTS(3), .N_HOURS(8), .ADDR_W(3), .DATA_W(16),
        .SCROLL_TICKS(4), .BLINK_TICKS(4)
    ) dut (
        .clk(clk), .reset(reset), .parking_status(parking_status),
        .work_hour(work_hour), .work_day_expired(work_day_expired),
        .rush_start(rush_start), .rush_start_exist(rush_start_exist),
        .rush_end(rush_end), .rush_end_exist(rush_end_exist),
        .ram_addr(ram_addr), .ram_data(ram_data),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
    );

    always #5 clk = ~clk;

    // Car-track RAM: word[a] = a+3, except word[0] = 120 to exercise saturation.
    function automatic logic [15:0] ram_word(input int a);
        return (a == 0) ? 16'd120 : 16'(a + 3);
    endfunction

    always @(posedge clk) ram_data <= ram_word(int'(ram_addr));

    function automatic logic [6:0] glyph(input int v);
        case (v)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return G_DASH;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        parking_status = 3'b000; work_hour = 4'd3; work_day_expired = 1'b0;
        rush_start = 4'd2; rush_end = 4'd5; rush_start_exist = 1'b1; rush_end_exist = 1'b1;
        tick(); tick();
        checks++;
        if ({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} !== {6{G_BLANK}})
            $display("FAIL reset_hex got %h want all %h", {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, G_BLANK);
        else passes++;
        checks++;
        if (ram_addr !== 3'd0) $display("FAIL reset_addr got %0d want 0", ram_addr);
        else passes++;
        $display("reset: HEX0=%b ram_addr=%0d", HEX0, ram_addr);
        reset = 1'b0;
    endtask

    task automatic test_day_count();
        logic [2:0] pat [0:2];
        pat[0] = 3'b000; pat[1] = 3'b001; pat[2] = 3'b011;
        for (int i = 0; i < 3; i++) begin
            parking_status = pat[i];
            tick();
            checks++;
            if (HEX0 !== glyph(3 - i)) $display("FAIL day_hex0 status=%b got %b want %b", pat[i], HEX0, glyph(3 - i));
            else passes++;
            checks++;
            if ({HEX4, HEX3, HEX2, HEX1} !== {4{G_BLANK}})
                $display("FAIL day_blank status=%b got %h want %h", pat[i], {HEX4, HEX3, HEX2, HEX1}, {4{G_BLANK}});
            else passes++;
            checks++;
            if (HEX5 !== glyph(3)) $display("FAIL day_hour got %b want %b", HEX5, glyph(3));
            else passes++;
            $display("day: status=%b HEX0=%b", pat[i], HEX0);
        end
    endtask

    task automatic test_hour_digit();
        work_hour = 4'd9;
        tick();
        checks++;
        if (HEX5 !== glyph(9)) $display("FAIL hour9 got %b want %b", HEX5, glyph(9));
        else passes++;
        work_hour = 4'd12;
        tick();
        checks++;
        if (HEX5 !== G_DASH) $display("FAIL hour12 got %b want %b", HEX5, G_DASH);
        else passes++;
        $display("hour: work_hour=12 HEX5=%b", HEX5);
        work_hour = 4'd3;
    endtask

    task automatic test_full_blink();
        logic [27:0] want;
        parking_status = 3'b111;
        for (int i = 0; i < 12; i++) begin
            tick();
            want = (((i / 4) % 2) == 0) ? {G_F, G_U, G_L, G_L} : {4{G_BLANK}};
            checks++;
            if ({HEX3, HEX2, HEX1, HEX0} !== want)
                $display("FAIL full_blink cyc=%0d got %h want %h", i, {HEX3, HEX2, HEX1, HEX0}, want);
            else passes++;
            checks++;
            if (HEX4 !== G_BLANK) $display("FAIL full_hex4 cyc=%0d got %b want %b", i, HEX4, G_BLANK);
            else passes++;
            $display("full: cyc=%0d HEX3..0=%h", i, {HEX3, HEX2, HEX1, HEX0});
        end
        parking_status = 3'b110;
        tick();
        checks++;
        if ({HEX3, HEX1, HEX0} !== {G_BLANK, G_BLANK, glyph(1)})
            $display("FAIL full_exit got %h want %h", {HEX3, HEX1, HEX0}, {G_BLANK, G_BLANK, glyph(1)});
        else passes++;
        $display("full exit: HEX0=%b", HEX0);
    endtask

    task automatic test_review_scroll();
        int a, m, am, c;
        parking_status = 3'b111;
        work_day_expired = 1'b1;
        for (int k = 0; k < 36; k++) begin
            tick();
            a = (7 - (k / 4) + 16) % 8;
            checks++;
            if (ram_addr !== 3'(a)) $display("FAIL scroll_addr k=%0d got %0d want %0d", k, ram_addr, a);
            else passes++;
            if (k == 0) begin
                checks++;
                if ({HEX4, HEX3} !== {glyph(5), glyph(2)})
                    $display("FAIL expiry_priority got %h want %h", {HEX4, HEX3}, {glyph(5), glyph(2)});
                else passes++;
            end
            if (k >= 1) begin
                am = (7 - ((k - 1) / 4) + 16) % 8;
                checks++;
                if (HEX2 !== glyph(am)) $display("FAIL scroll_hex2 k=%0d got %b want %b", k, HEX2, glyph(am));
                else passes++;
            end
            if (k >= 2) begin
                m = (k - 2) / 4;
                am = (7 - m + 16) % 8;
                c = int'(ram_word(am));
                if (c > 99) c = 99;
                checks++;
                if ({HEX1, HEX0} !== {glyph(c / 10), glyph(c % 10)})
                    $display("FAIL scroll_data k=%0d addr=%0d got %h want %h", k, am, {HEX1, HEX0}, {glyph(c / 10), glyph(c % 10)});
                else passes++;
            end
            $display("review: k=%0d ram_addr=%0d HEX2=%b HEX1:0=%h", k, ram_addr, HEX2, {HEX1, HEX0});
        end
    endtask

    task automatic test_rush();
        logic [1:0]  ex [0:3];
        logic [13:0] want [0:3];
        ex[0] = 2'b00; want[0] = {G_DASH, G_DASH};
        ex[1] = 2'b01; want[1] = {G_DASH, glyph(2)};
        ex[2] = 2'b10; want[2] = {G_DASH, G_DASH};
        ex[3] = 2'b11; want[3] = {glyph(5), glyph(2)};
        for (int i = 0; i < 4; i++) begin
            {rush_end_exist, rush_start_exist} = ex[i];
            tick();
            checks++;
            if ({HEX4, HEX3} !== want[i])
                $display("FAIL rush exist=%b got %h want %h", ex[i], {HEX4, HEX3}, want[i]);
            else passes++;
            $display("rush: exist=%b HEX4:3=%h", ex[i], {HEX4, HEX3});
        end
    endtask

    task automatic test_mid_reset();
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({HEX4, HEX3, HEX2, HEX1, HEX0, ram_addr} !== {{5{G_BLANK}}, 3'd0})
            $display("FAIL reset_mid_review got %h want %h", {HEX4, HEX3, HEX2, HEX1, HEX0, ram_addr}, {{5{G_BLANK}}, 3'd0});
        else passes++;
        reset = 1'b0;
        parking_status = 3'b011;
        tick();
        checks++;
        if (ram_addr !== 3'd7) $display("FAIL reentry_addr got %0d want 7", ram_addr);
        else passes++;
        work_day_expired = 1'b0;
        tick();
        checks++;
        if ({HEX3, HEX1, HEX0} !== {G_BLANK, G_BLANK, glyph(1)})
            $display("FAIL review_to_day got %h want %h", {HEX3, HEX1, HEX0}, {G_BLANK, G_BLANK, glyph(1)});
        else passes++;
        $display("mid reset review: back to day HEX0=%b", HEX0);

        parking_status = 3'b111;
        for (int i = 0; i < 6; i++) tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({HEX3, HEX2, HEX1, HEX0, ram_addr} !== {{4{G_BLANK}}, 3'd0})
            $display("FAIL reset_mid_full got %h want %h", {HEX3, HEX2, HEX1, HEX0, ram_addr}, {{4{G_BLANK}}, 3'd0});
        else passes++;
        reset = 1'b0;
        tick();
        checks++;
        if ({HEX3, HEX2, HEX1, HEX0} !== {G_F, G_U, G_L, G_L})
            $display("FAIL full_after_reset got %h want %h", {HEX3, HEX2, HEX1, HEX0}, {G_F, G_U, G_L, G_L});
        else passes++;
        $display("mid reset full: HEX3..0=%h", {HEX3, HEX2, HEX1, HEX0});
    endtask

    initial begin
        test_reset();
        test_day_count();
        test_hour_digit();
        test_full_blink();
        test_review_scroll();
        test_rush();
        test_mid_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
